sbuf_scanout: RTL

SBUF_SCANOUT -- requirements
Module: sbuf_scanout

---
 rtl/sbuf_scanout.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/sbuf_scanout.sv
// sbuf_scanout: 720p scan-out of an upscaled, letterboxed screen buffer.
// Raw 1650x750 counters drive a read address into a synchronous buffer.
// Sync and active signals are delayed READ_LATENCY+1 cycles so they line
// up with the registered RGB888 pixel expanded from the RGB565 read data.
module sbuf_scanout #(
  parameter int FRAME_WIDTH  = 256,
  parameter int FRAME_HEIGHT = 128,
  parameter int SCALE        = 5,
  parameter int V_OFFSET     = 40,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic [15:0] sbuf_addr,
  output logic        sbuf_read_enable,
  input  logic [15:0] sbuf_data,
  output logic        hsync,
  output logic        vsync,
  output logic        active_draw,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        frame_start
);

  localparam int L     = READ_LATENCY + 1;
  localparam int PX_W  = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
  localparam int PY_W  = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [10:0] H_LAST      = 11'd1649;
  localparam logic [9:0]  V_LAST      = 10'd749;
  localparam logic [10:0] H_ACTIVE    = 11'd1280;
  localparam logic [9:0]  V_ACTIVE    = 10'd720;
  localparam logic [10:0] HS_FIRST    = 11'd1390;
  localparam logic [10:0] HS_LAST     = 11'd1429;
  localparam logic [9:0]  VS_FIRST    = 10'd725;
  localparam logic [9:0]  VS_LAST     = 10'd729;
  localparam logic [10:0] H_IMG_END   = 11'(FRAME_WIDTH * SCALE);
  localparam logic [9:0]  V_IMG_FIRST = 10'(V_OFFSET);
  localparam logic [9:0]  V_IMG_LAST  = 10'(V_OFFSET + FRAME_HEIGHT * SCALE - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALE - 1);

  // run_q holds the counters at (0,0) for the first edge after reset release
  logic                    run_q, run_d;
  logic [10:0]             h_q, h_d;
  logic [9:0]              v_q, v_d;
  logic [SUB_W-1:0]        hsub_q, hsub_d, vsub_q, vsub_d;
  logic [PX_W-1:0]         px_q, px_d;
  logic [PY_W-1:0]         py_q, py_d;
  logic [15:0]             addr_q, addr_d;
  logic                    ren_q, ren_d;
  logic                    frame_start_q, frame_start_d;
  logic [L-1:0]            hs_pipe_q, hs_pipe_d;
  logic [L-1:0]            vs_pipe_q, vs_pipe_d;
  logic [L-1:0]            act_pipe_q, act_pipe_d;
  logic [READ_LATENCY-1:0] img_pipe_q, img_pipe_d;
  logic [7:0]              red_q, red_d, green_q, green_d, blue_q, blue_d;

  logic h_img, v_img, img_d;
  logic hs_raw, vs_raw, act_raw;

  // Raw counters, upscale sub-counters and the registered read address
  always_comb begin
    run_d  = 1'b1;
    h_d    = h_q;
    v_d    = v_q;
    hsub_d = hsub_q;
    px_d   = px_q;
    vsub_d = vsub_q;
    py_d   = py_q;
    h_img  = (h_q < H_IMG_END);
    v_img  = (v_q >= V_IMG_FIRST) && (v_q <= V_IMG_LAST);
    if (run_q) begin
      if (h_q == H_LAST) begin
        h_d    = '0;
        hsub_d = '0;
        px_d   = '0;
        if (v_q == V_LAST) begin
          v_d    = '0;
          vsub_d = '0;
          py_d   = '0;
        end else begin
          v_d = v_q + 10'd1;
          if (v_img) begin
            if (vsub_q == SUB_LAST) begin
              vsub_d = '0;
              py_d   = py_q + PY_W'(1);
            end else begin
              vsub_d = vsub_q + SUB_W'(1);
            end
          end
        end
      end else begin
        h_d = h_q + 11'd1;
        if (h_img) begin
          if (hsub_q == SUB_LAST) begin
            hsub_d = '0;
            px_d   = px_q + PX_W'(1);
          end else begin
            hsub_d = hsub_q + SUB_W'(1);
          end
        end
      end
    end
    img_d  = (h_d < H_IMG_END) && (v_d >= V_IMG_FIRST) && (v_d <= V_IMG_LAST);
    ren_d  = img_d;
    addr_d = img_d ? 16'({py_d, px_d}) : addr_q;
    frame_start_d = run_q && (h_q == H_LAST) && (v_q == V_LAST);
  end

  // Timing decode of the raw position and the delay pipelines
  always_comb begin
    hs_raw  = run_q && (h_q >= HS_FIRST) && (h_q <= HS_LAST);
    vs_raw  = run_q && (v_q >= VS_FIRST) && (v_q <= VS_LAST);
    act_raw = run_q && (h_q < H_ACTIVE) && (v_q < V_ACTIVE);
    hs_pipe_d  = '0;
    vs_pipe_d  = '0;
    act_pipe_d = '0;
    img_pipe_d = '0;
    hs_pipe_d[0]  = hs_raw;
    vs_pipe_d[0]  = vs_raw;
    act_pipe_d[0] = act_raw;
    // ren_q is exactly "this raw position is inside the image"
    img_pipe_d[0] = ren_q;
    for (int i = 1; i < L; i++) begin
      hs_pipe_d[i]  = hs_pipe_q[i-1];
      vs_pipe_d[i]  = vs_pipe_q[i-1];
      act_pipe_d[i] = act_pipe_q[i-1];
    end
    for (int i = 1; i < READ_LATENCY; i++) begin
      img_pipe_d[i] = img_pipe_q[i-1];
    end
  end

  // RGB565 to RGB888 expansion, blanked outside the image region
  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (img_pipe_q[READ_LATENCY-1]) begin
      red_d   = {sbuf_data[15:11], sbuf_data[15:13]};
      green_d = {sbuf_data[10:5],  sbuf_data[10:9]};
      blue_d  = {sbuf_data[4:0],   sbuf_data[4:2]};
    end
  end

  // State register; every flop clears asynchronously on reset
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      run_q         <= 1'b0;
      h_q           <= '0;
      v_q           <= '0;
      hsub_q        <= '0;
      px_q          <= '0;
      vsub_q        <= '0;
      py_q          <= '0;
      addr_q        <= '0;
      ren_q         <= 1'b0;
      frame_start_q <= 1'b0;
      hs_pipe_q     <= '0;
      vs_pipe_q     <= '0;
      act_pipe_q    <= '0;
      img_pipe_q    <= '0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
    end else begin
      run_q         <= run_d;
      h_q           <= h_d;
      v_q           <= v_d;
      hsub_q        <= hsub_d;
      px_q          <= px_d;
      vsub_q        <= vsub_d;
      py_q          <= py_d;
      addr_q        <= addr_d;
      ren_q         <= ren_d;
      frame_start_q <= frame_start_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      act_pipe_q    <= act_pipe_d;
      img_pipe_q    <= img_pipe_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
    end
  end

  assign sbuf_addr        = addr_q;
  assign sbuf_read_enable = ren_q;
  assign frame_start      = frame_start_q;
  assign hsync            = hs_pipe_q[L-1];
  assign vsync            = vs_pipe_q[L-1];
  assign active_draw      = act_pipe_q[L-1];
  assign red              = red_q;
  assign green            = green_q;
  assign blue             = blue_q;

endmodule
